// File: rtl/clause_evaluator.sv
// clause_evaluator: drives one port of the single-bit variable table to evaluate
// a K-literal clause (true-literal count) or to flip one variable (read-modify-write).
module clause_evaluator #(
   parameter int VARIABLE_ADDRESS_WIDTH = 11,
   parameter int LITERALS_PER_CLAUSE    = 3
) (
   input  logic                                                       clk,
   input  logic                                                       rst,
   input  logic                                                       cmd_valid,
   output logic                                                       cmd_ready,
   input  logic                                                       cmd_op,
   input  logic [LITERALS_PER_CLAUSE*(VARIABLE_ADDRESS_WIDTH+1)-1:0]  cmd_lits,
   input  logic [LITERALS_PER_CLAUSE-1:0]                             cmd_lit_mask,
   input  logic [VARIABLE_ADDRESS_WIDTH-1:0]                          flip_addr,
   output logic                                                       vt_en,
   output logic                                                       vt_we,
   output logic [VARIABLE_ADDRESS_WIDTH-1:0]                          vt_addr,
   output logic                                                       vt_din,
   input  logic                                                       vt_dout,
   output logic                                                       res_valid,
   input  logic                                                       res_ready,
   output logic                                                       res_sat,
   output logic [$clog2(LITERALS_PER_CLAUSE+1)-1:0]                   res_true_count,
   output logic                                                       res_old_value
);

   localparam int W     = VARIABLE_ADDRESS_WIDTH;
   localparam int K     = LITERALS_PER_CLAUSE;
   localparam int LW    = W + 1;
   localparam int CNT_W = $clog2(K + 1);
   localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_LAST, S_F_RD, S_F_WR, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                old_q, old_d;
   logic [K*LW-1:0]     lits_q, lits_d;
   logic [K-1:0]        mask_q, mask_d;
   logic [W-1:0]        faddr_q, faddr_d;

   logic [W-1:0]        lit_addr [K];
   logic                lit_neg  [K];
   logic [IDX_W-1:0]    cap_idx;
   logic                cap_true;
   logic                en_c, we_c, din_c;
   logic [W-1:0]        addr_c;

   always_comb begin
      for (int unsigned i = 0; i < K; i++) begin
         lit_addr[i] = lits_q[i*LW +: W];
         lit_neg[i]  = lits_q[i*LW + W];
      end
   end

   // Read data returned now belongs to the slot issued one cycle earlier;
   // in LAST the index has stopped advancing, so it already points at K-1.
   always_comb begin
      cap_idx  = (state_q == S_LAST) ? idx_q : idx_q - IDX_W'(1);
      cap_true = mask_q[cap_idx] & (vt_dout ^ lit_neg[cap_idx]);
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      old_d     = old_q;
      lits_d    = lits_q;
      mask_d    = mask_q;
      faddr_d   = faddr_q;
      en_c      = 1'b0;
      we_c      = 1'b0;
      din_c     = 1'b0;
      addr_c    = '0;
      res_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               lits_d  = cmd_lits;
               mask_d  = cmd_lit_mask;
               faddr_d = flip_addr;
               idx_d   = '0;
               cnt_d   = '0;
               old_d   = 1'b0;
               state_d = cmd_op ? S_F_RD : S_RD;
            end
         end
         S_RD: begin
            en_c   = mask_q[idx_q];
            addr_c = lit_addr[idx_q];
            if (idx_q != '0 && cap_true) cnt_d = cnt_q + CNT_W'(1);
            if (idx_q == LAST_IDX) state_d = S_LAST;
            else                   idx_d   = idx_q + IDX_W'(1);
         end
         S_LAST: begin
            if (cap_true) cnt_d = cnt_q + CNT_W'(1);
            state_d = S_DONE;
         end
         S_F_RD: begin
            en_c    = 1'b1;
            addr_c  = faddr_q;
            state_d = S_F_WR;
         end
         S_F_WR: begin
            en_c    = 1'b1;
            we_c    = 1'b1;
            addr_c  = faddr_q;
            din_c   = ~vt_dout;
            old_d   = vt_dout;
            state_d = S_DONE;
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         old_q   <= 1'b0;
         lits_q  <= '0;
         mask_q  <= '0;
         faddr_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         old_q   <= old_d;
         lits_q  <= lits_d;
         mask_q  <= mask_d;
         faddr_q <= faddr_d;
      end
   end

   // Port is gated off during reset so a reset in F_WR suppresses the write.
   assign cmd_ready      = (state_q == S_IDLE) & ~rst;
   assign vt_en          = en_c & ~rst;
   assign vt_we          = we_c & ~rst;
   assign vt_din         = din_c & ~rst;
   assign vt_addr        = rst ? '0 : addr_c;
   assign res_sat        = |cnt_q;
   assign res_true_count = cnt_q;
   assign res_old_value  = old_q;

endmodule

// File: tb/tb_clause_evaluator.sv
// Bench for clause_evaluator: directed vector table, hand-written corner sequences
// and randomized commands checked against a behavioural variable-table model.
module tb_clause_evaluator;

   localparam int W      = 11;
   localparam int K      = 3;
   localparam int LW     = W + 1;
   localparam int LITS_W = K * LW;
   localparam int CNT_W  = $clog2(K + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid, cmd_ready, cmd_op;
   logic [LITS_W-1:0] cmd_lits;
   logic [K-1:0]      cmd_lit_mask;
   logic [W-1:0]      flip_addr;
   logic              vt_en, vt_we, vt_din, vt_dout;
   logic [W-1:0]      vt_addr;
   logic              res_valid, res_ready, res_sat, res_old_value;
   logic [CNT_W-1:0]  res_true_count;

   clause_evaluator #(
      .VARIABLE_ADDRESS_WIDTH(W),
      .LITERALS_PER_CLAUSE(K)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_lits(cmd_lits), .cmd_lit_mask(cmd_lit_mask), .flip_addr(flip_addr),
      .vt_en(vt_en), .vt_we(vt_we), .vt_addr(vt_addr), .vt_din(vt_din), .vt_dout(vt_dout),
      .res_valid(res_valid), .res_ready(res_ready), .res_sat(res_sat),
      .res_true_count(res_true_count), .res_old_value(res_old_value)
   );

   always #5 clk = ~clk;

   // Variable table: one read-first port plus a backdoor preload port.
   logic         mem [2**W] = '{default: 1'b0};
   logic         bd_we, bd_din;
   logic [W-1:0] bd_addr;
   logic         dout_r = 1'b0;
   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_din;
      else if (vt_en) begin
         if (vt_we) mem[vt_addr] <= vt_din;
         dout_r <= mem[vt_addr];
      end
   end
   assign vt_dout = dout_r;

   // Reference view of the table, updated only from command semantics.
   bit ref_tbl [2**W];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int           n;
      bit           we;
      logic [W-1:0] addr;
      bit           din;
   } acc_t;
   acc_t acc_q[$];

   function automatic logic [LITS_W-1:0] mk(input bit n0, input int a0, input bit n1, input int a1,
                                             input bit n2, input int a2);
      logic [W-1:0] x0, x1, x2;
      x0 = W'(a0); x1 = W'(a1); x2 = W'(a2);
      return {n2, x2, n1, x1, n0, x0};
   endfunction

   function automatic int ref_eval(input logic [LITS_W-1:0] lits, input logic [K-1:0] mask);
      int c = 0;
      for (int i = 0; i < K; i++) begin
         logic [LW-1:0] l;
         l = lits[i*LW +: LW];
         if (mask[i] && (ref_tbl[l[W-1:0]] != l[W])) c++;
      end
      return c;
   endfunction

   task automatic run_cmd(input bit op, input logic [LITS_W-1:0] lits, input logic [K-1:0] mask,
                          input logic [W-1:0] fa, input int stall,
                          output int lat, output bit sat, output int cnt, output bit old);
      int guard = 0;
      acc_q.delete();
      while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
      chk("cmd_ready_wait", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_lits = lits; cmd_lit_mask = mask; flip_addr = fa;
      @(posedge clk);
      @(negedge clk);
      cmd_valid    = 1'b0;
      cmd_op       = ~op;
      cmd_lits     = LITS_W'({$urandom(), $urandom()});
      cmd_lit_mask = ~mask;
      flip_addr    = W'($urandom());
      lat = 1;
      while (!res_valid && lat < 20) begin
         if (vt_en) acc_q.push_back('{lat, vt_we, vt_addr, vt_din});
         @(negedge clk);
         lat++;
      end
      sat = res_sat; cnt = int'(res_true_count); old = res_old_value;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("stall_res_valid", res_valid, 1);
         chk("stall_res_stable", {res_sat, res_old_value, 30'(res_true_count)},
             {sat, old, 30'(cnt)});
         chk("stall_cmd_ready", cmd_ready, 0);
         chk("stall_vt_en", vt_en, 0);
      end
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      chk("res_valid_drop", res_valid, 0);
      chk("cmd_ready_after", cmd_ready, 1);
   endtask

   task automatic chk_access(input bit op, input logic [LITS_W-1:0] lits, input logic [K-1:0] mask,
                             input logic [W-1:0] fa, input bit exp_old);
      acc_t e[$];
      if (op) begin
         e.push_back('{1, 1'b0, fa, 1'b0});
         e.push_back('{2, 1'b1, fa, ~exp_old});
      end else begin
         for (int i = 0; i < K; i++)
            if (mask[i]) e.push_back('{i + 1, 1'b0, lits[i*LW +: W], 1'b0});
      end
      chk("acc_count", acc_q.size(), e.size());
      if (acc_q.size() == e.size()) begin
         foreach (e[j]) begin
            chk("acc_cycle", acc_q[j].n, e[j].n);
            chk("acc_we", acc_q[j].we, e[j].we);
            chk("acc_addr", acc_q[j].addr, e[j].addr);
            if (e[j].we) chk("acc_din", acc_q[j].din, e[j].din);
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_res_fields"}, {res_sat, res_old_value, 30'(res_true_count)}, 0);
      chk({tag, "_vt_port"}, {vt_en, vt_we, vt_din, 29'(vt_addr)}, 0);
   endtask

   typedef struct {
      bit                op;
      logic [LITS_W-1:0] lits;
      logic [K-1:0]      mask;
      logic [W-1:0]      fa;
      bit                e_sat;
      int                e_cnt;
      bit                e_old;
   } vec_t;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[$];
      int lat, cnt;
      bit sat, old;

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_lits = '0; cmd_lit_mask = '0;
      flip_addr = '0; res_ready = 1'b0;
      bd_we = 1'b1; bd_addr = W'(5); bd_din = 1'b1;
      ref_tbl[5] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bd_we = 1'b0;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      vecs.push_back('{1'b0, mk(0, 5, 0, 9, 1, 12), 3'b111, '0, 1'b1, 2, 1'b0});
      vecs.push_back('{1'b0, mk(1, 5, 0, 9, 0, 12), 3'b111, '0, 1'b0, 0, 1'b0});
      vecs.push_back('{1'b0, mk(0, 9, 0, 5, 1, 12), 3'b010, '0, 1'b1, 1, 1'b0});
      vecs.push_back('{1'b0, mk(1, 9, 1, 12, 0, 5), 3'b000, '0, 1'b0, 0, 1'b0});
      vecs.push_back('{1'b1, '0, 3'b000, W'(9), 1'b0, 0, 1'b0});
      vecs.push_back('{1'b0, mk(0, 9, 0, 0, 0, 0), 3'b001, '0, 1'b1, 1, 1'b0});
      vecs.push_back('{1'b1, '0, 3'b000, W'(9), 1'b0, 0, 1'b1});
      vecs.push_back('{1'b0, mk(0, 5, 0, 5, 1, 9), 3'b111, '0, 1'b1, 3, 1'b0});
      vecs.push_back('{1'b0, mk(1, 12, 0, 5, 0, 9), 3'b101, '0, 1'b1, 1, 1'b0});

      foreach (vecs[v]) begin
         run_cmd(vecs[v].op, vecs[v].lits, vecs[v].mask, vecs[v].fa, 0, lat, sat, cnt, old);
         chk($sformatf("vec%0d_latency", v), lat, vecs[v].op ? 3 : K + 2);
         chk($sformatf("vec%0d_sat", v), sat, vecs[v].e_sat);
         chk($sformatf("vec%0d_count", v), cnt, vecs[v].e_cnt);
         chk($sformatf("vec%0d_old", v), old, vecs[v].e_old);
         chk_access(vecs[v].op, vecs[v].lits, vecs[v].mask, vecs[v].fa, vecs[v].e_old);
         if (vecs[v].op) ref_tbl[vecs[v].fa] = ~ref_tbl[vecs[v].fa];
      end

      // Result held in DONE with res_ready low.
      run_cmd(1'b0, mk(0, 5, 0, 9, 1, 12), 3'b111, '0, 4, lat, sat, cnt, old);
      chk("stall_count", cnt, 2);
      chk("stall_sat", sat, 1);

      // Reset during the F_WR cycle of a flip of v5.
      cmd_valid = 1'b1; cmd_op = 1'b1; flip_addr = W'(5); cmd_lit_mask = '0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("rst_frd_port", {vt_en, vt_we, 30'(vt_addr)}, {1'b1, 1'b0, 30'd5});
      @(negedge clk);
      chk("rst_fwr_we", vt_we, 1);
      rst = 1'b1;
      #1;
      chk("rst_fwr_gated", {vt_en, vt_we}, 0);
      @(negedge clk);
      chk_reset_outputs("after_rst");
      rst = 1'b0;
      @(negedge clk);
      chk("rst_recover_ready", cmd_ready, 1);
      run_cmd(1'b0, mk(0, 5, 0, 0, 0, 0), 3'b001, '0, 0, lat, sat, cnt, old);
      chk("rst_nowrite_sat", sat, 1);
      chk("rst_nowrite_count", cnt, 1);

      for (int r = 0; r < 40; r++) begin
         bit                op;
         logic [LITS_W-1:0] lits;
         logic [K-1:0]      mask;
         logic [W-1:0]      fa;
         int                e_cnt;
         bit                e_old;
         op   = ($urandom_range(0, 2) == 0);
         lits = mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                   $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15));
         mask = K'($urandom());
         fa   = W'($urandom_range(0, 15));
         e_cnt = 0; e_old = 1'b0;
         if (op) begin
            e_old = ref_tbl[fa];
            ref_tbl[fa] = ~ref_tbl[fa];
         end else begin
            e_cnt = ref_eval(lits, mask);
         end
         run_cmd(op, lits, mask, fa, $urandom_range(0, 2), lat, sat, cnt, old);
         chk("rnd_latency", lat, op ? 3 : K + 2);
         chk("rnd_count", cnt, e_cnt);
         chk("rnd_sat", sat, e_cnt != 0);
         chk("rnd_old", old, e_old);
         chk_access(op, lits, mask, fa, e_old);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
